byte_read_serializer: RTL and testbench

Transmit-side counterpart of the byte-addressed write register on the IP packet path. Accepts one `SIZE_IN_BYTES`-wide word through a valid/ready load handshake, then streams it out one byte per beat, lowest byte first, over a valid/ready byte interface. Each beat carries its byte number and a last flag. The block sits between the packet-assembly logic and the byte-wide MAC/TX FIFO.

---
 rtl/ip_packet_pkg.sv | 16 +
 rtl/byte_read_mux.sv | 20 ++
 rtl/byte_read_serializer.sv | 128 ++++++++++++
 tb/tb_byte_read_serializer.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/ip_packet_pkg.sv
// Shared types for the IP packet path: transmit FSM states, header size
// and the byte-index type used by the byte-addressed registers.
package ip_packet_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    CSUM = 2'd2
  } tx_state_t;

  localparam int IP_HDR_BYTES = 13;
  localparam int BYTE_IDX_W   = 4;

  typedef logic [BYTE_IDX_W-1:0] byte_idx_t;

endpackage

// File: rtl/byte_read_mux.sv
// Combinational byte selector: returns byte[sel] of a wide word, using the
// same byte k = bits [8k+7:8k] addressing as the write-side register.
module byte_read_mux #(
  parameter int SIZE_IN_BYTES = 13,
  parameter int BYTE_NUM_SIZE = 4
) (
  input  logic [SIZE_IN_BYTES*8-1:0] word,
  input  logic [BYTE_NUM_SIZE-1:0]   sel,
  output logic [7:0]                 byte_out
);

  // Out-of-range indices read as zero.
  always_comb begin
    byte_out = 8'h00;
    for (int k = 0; k < SIZE_IN_BYTES; k++) begin
      if (sel == BYTE_NUM_SIZE'(k)) byte_out = word[8*k +: 8];
    end
  end

endmodule

// File: rtl/byte_read_serializer.sv
// Loads one wide word via valid/ready and streams it out LSB byte first.
// Define BYTE_READ_SERIALIZER_CHECKSUM_EN to append an XOR checksum beat.
module byte_read_serializer
  import ip_packet_pkg::*;
#(
  parameter int SIZE_IN_BYTES = IP_HDR_BYTES,
  parameter int BYTE_NUM_SIZE = BYTE_IDX_W
) (
  input  logic                       CLK,
  input  logic                       ARESET,
  input  logic                       LOAD_VALID,
  output logic                       LOAD_READY,
  input  logic [SIZE_IN_BYTES*8-1:0] LOAD_VALUE,
  output logic                       OUT_VALID,
  input  logic                       OUT_READY,
  output logic [7:0]                 OUTPUT_VALUE,
  output logic [BYTE_NUM_SIZE-1:0]   BYTE_NUM,
  output logic                       OUT_LAST
);

  localparam logic [BYTE_NUM_SIZE-1:0] LAST_IDX = BYTE_NUM_SIZE'(SIZE_IN_BYTES - 1);

  tx_state_t                  state, nxt_state;
  logic [BYTE_NUM_SIZE-1:0]   cnt;
  logic [SIZE_IN_BYTES*8-1:0] shadow;
  logic [7:0]                 mux_byte;
  logic                       final_acc;
  logic                       load_acc;
  logic                       send_acc;

`ifdef BYTE_READ_SERIALIZER_CHECKSUM_EN
  logic [7:0] csum;

  function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction
`endif

  byte_read_mux #(
    .SIZE_IN_BYTES(SIZE_IN_BYTES),
    .BYTE_NUM_SIZE(BYTE_NUM_SIZE)
  ) u_mux (
    .word    (shadow),
    .sel     (cnt),
    .byte_out(mux_byte)
  );

  assign send_acc = (state == SEND) && OUT_READY;

`ifdef BYTE_READ_SERIALIZER_CHECKSUM_EN
  assign final_acc = (state == CSUM) && OUT_READY;
`else
  assign final_acc = send_acc && (cnt == LAST_IDX);
`endif

  // Ready may rise combinationally on the final beat so words run back-to-back.
  assign LOAD_READY = ARESET && ((state == IDLE) || final_acc);
  assign load_acc   = LOAD_VALID && LOAD_READY;

  always_ff @(posedge CLK or negedge ARESET) begin
    if (!ARESET) state <= IDLE;
    else         state <= nxt_state;
  end

  always_comb begin
    nxt_state = state;
    case (state)
      IDLE: nxt_state = IDLE;
`ifdef BYTE_READ_SERIALIZER_CHECKSUM_EN
      SEND: if (send_acc && (cnt == LAST_IDX)) nxt_state = CSUM;
      CSUM: if (final_acc) nxt_state = IDLE;
`else
      SEND: if (final_acc) nxt_state = IDLE;
`endif
      default: nxt_state = IDLE;
    endcase
    if (load_acc) nxt_state = SEND;
  end

  // After the last data byte the counter naturally reads SIZE_IN_BYTES,
  // which is exactly the index the checksum beat reports.
  always_ff @(posedge CLK or negedge ARESET) begin
    if (!ARESET) begin
      cnt    <= '0;
      shadow <= '0;
    end else if (load_acc) begin
      cnt    <= '0;
      shadow <= LOAD_VALUE;
    end else if (send_acc) begin
      cnt    <= cnt + 1'b1;
    end
  end

`ifdef BYTE_READ_SERIALIZER_CHECKSUM_EN
  always_ff @(posedge CLK or negedge ARESET) begin
    if (!ARESET)       csum <= 8'h00;
    else if (load_acc) csum <= 8'h00;
    else if (send_acc) csum <= csum_step(csum, mux_byte);
  end
`endif

  always_comb begin
    OUT_VALID    = 1'b0;
    OUTPUT_VALUE = 8'h00;
    BYTE_NUM     = '0;
    OUT_LAST     = 1'b0;
    case (state)
      SEND: begin
        OUT_VALID    = 1'b1;
        OUTPUT_VALUE = mux_byte;
        BYTE_NUM     = cnt;
`ifndef BYTE_READ_SERIALIZER_CHECKSUM_EN
        OUT_LAST     = (cnt == LAST_IDX);
`endif
      end
`ifdef BYTE_READ_SERIALIZER_CHECKSUM_EN
      CSUM: begin
        OUT_VALID    = 1'b1;
        OUTPUT_VALUE = csum;
        BYTE_NUM     = cnt;
        OUT_LAST     = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_byte_read_serializer.sv
// Directed bench for byte_read_serializer: reset, serialize, backpressure,
// back-to-back loads, mid-word reset, and the optional checksum beat.
module tb_byte_read_serializer;

  localparam int NBYTES = 13;
`ifdef BYTE_READ_SERIALIZER_CHECKSUM_EN
  localparam int NBEATS = NBYTES + 1;
`else
  localparam int NBEATS = NBYTES;
`endif

  logic               CLK = 1'b0;
  logic               ARESET;
  logic               LOAD_VALID;
  logic               LOAD_READY;
  logic [NBYTES*8-1:0] LOAD_VALUE;
  logic               OUT_VALID;
  logic               OUT_READY;
  logic [7:0]         OUTPUT_VALUE;
  logic [3:0]         BYTE_NUM;
  logic               OUT_LAST;

  int n_assert = 0;
  int n_fail   = 0;

  byte_read_serializer #(.SIZE_IN_BYTES(NBYTES), .BYTE_NUM_SIZE(4)) dut (
    .CLK         (CLK),
    .ARESET      (ARESET),
    .LOAD_VALID  (LOAD_VALID),
    .LOAD_READY  (LOAD_READY),
    .LOAD_VALUE  (LOAD_VALUE),
    .OUT_VALID   (OUT_VALID),
    .OUT_READY   (OUT_READY),
    .OUTPUT_VALUE(OUTPUT_VALUE),
    .BYTE_NUM    (BYTE_NUM),
    .OUT_LAST    (OUT_LAST)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NBYTES*8-1:0] mk(input logic [7:0] base, input logic [7:0] step);
    logic [NBYTES*8-1:0] w;
    w = '0;
    for (int k = 0; k < NBYTES; k++) w[8*k +: 8] = base + 8'(k) * step;
    return w;
  endfunction

  // Checks one full word starting at the current beat-0 negedge, optionally
  // stalling OUT_READY for 3 cycles on one beat; leaves time at the negedge
  // after the final beat.
  task automatic stream(input string tag, input logic [NBYTES*8-1:0] w,
                        input int stall_at, input bit drop_valid);
    logic [7:0] exp_v;
    logic [7:0] xr;
    xr = 8'h00;
    for (int k = 0; k < NBEATS; k++) begin
      if (k < NBYTES) begin
        exp_v = w[8*k +: 8];
        xr    = xr ^ exp_v;
      end else begin
        exp_v = xr;
      end
      chk({tag, "_valid"}, 32'(OUT_VALID), 32'd1);
      chk({tag, "_data"},  32'(OUTPUT_VALUE), 32'(exp_v));
      chk({tag, "_num"},   32'(BYTE_NUM), 32'(k));
      chk({tag, "_last"},  32'(OUT_LAST), 32'(k == NBEATS - 1));
      chk({tag, "_ldrdy"}, 32'(LOAD_READY), 32'(k == NBEATS - 1));
      if (k == 0 && drop_valid) LOAD_VALID = 1'b0;
      if (k == stall_at) begin
        OUT_READY = 1'b0;
        for (int s = 0; s < 3; s++) begin
          @(negedge CLK);
          chk({tag, "_hold_data"}, 32'(OUTPUT_VALUE), 32'(exp_v));
          chk({tag, "_hold_num"},  32'(BYTE_NUM), 32'(k));
          chk({tag, "_hold_vld"},  32'(OUT_VALID), 32'd1);
          chk({tag, "_hold_rdy"},  32'(LOAD_READY), 32'd0);
        end
        OUT_READY = 1'b1;
      end
      @(negedge CLK);
    end
  endtask

  initial begin
    logic [NBYTES*8-1:0] wa, wb, wc, wd, wk;
    wk = mk(8'h00, 8'h01);
    wa = mk(8'h10, 8'h01);
    wb = mk(8'h80, 8'h03);
    wc = mk(8'h55, 8'h07);
    wd = mk(8'hA0, 8'h01);

    ARESET = 1'b0; LOAD_VALID = 1'b0; LOAD_VALUE = '0; OUT_READY = 1'b0;

    // Reset held for 2 cycles: everything low
    repeat (2) @(negedge CLK);
    chk("rst_valid", 32'(OUT_VALID), 32'd0);
    chk("rst_data",  32'(OUTPUT_VALUE), 32'd0);
    chk("rst_num",   32'(BYTE_NUM), 32'd0);
    chk("rst_last",  32'(OUT_LAST), 32'd0);
    chk("rst_ldrdy", 32'(LOAD_READY), 32'd0);
    ARESET = 1'b1;
    @(negedge CLK);
    chk("post_rst_ldrdy", 32'(LOAD_READY), 32'd1);
    chk("post_rst_valid", 32'(OUT_VALID), 32'd0);

    // Basic serialize, bytes 0..12
    OUT_READY = 1'b1; LOAD_VALID = 1'b1; LOAD_VALUE = wk;
    @(negedge CLK);
    LOAD_VALID = 1'b0; LOAD_VALUE = '1;
    stream("basic", wk, -1, 1'b0);
    chk("basic_idle_valid", 32'(OUT_VALID), 32'd0);
    chk("basic_idle_ldrdy", 32'(LOAD_READY), 32'd1);

    // Backpressure on byte 5
    LOAD_VALID = 1'b1; LOAD_VALUE = wk;
    @(negedge CLK);
    LOAD_VALID = 1'b0;
    stream("bp", wk, 5, 1'b0);
    chk("bp_idle_valid", 32'(OUT_VALID), 32'd0);

    // Back-to-back: LOAD_VALID held, value switched to B while A is sending
    LOAD_VALID = 1'b1; LOAD_VALUE = wa;
    @(negedge CLK);
    LOAD_VALUE = wb;
    stream("b2b_a", wa, -1, 1'b0);
    stream("b2b_b", wb, -1, 1'b1);
    chk("b2b_idle_valid", 32'(OUT_VALID), 32'd0);

    // Reset mid-word after byte 4 accepted
    LOAD_VALID = 1'b1; LOAD_VALUE = wd;
    @(negedge CLK);
    LOAD_VALID = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("mid_data", 32'(OUTPUT_VALUE), 32'(8'hA0 + 8'(k)));
      @(negedge CLK);
    end
    chk("mid_byte5", 32'(BYTE_NUM), 32'd5);
    ARESET = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(OUT_VALID), 32'd0);
    chk("mid_rst_ldrdy", 32'(LOAD_READY), 32'd0);
    chk("mid_rst_data",  32'(OUTPUT_VALUE), 32'd0);
    @(negedge CLK);
    ARESET = 1'b1;
    LOAD_VALID = 1'b1; LOAD_VALUE = wc;
    @(negedge CLK);
    LOAD_VALID = 1'b0;
    stream("restart", wc, -1, 1'b0);
    chk("restart_idle_valid", 32'(OUT_VALID), 32'd0);

`ifdef BYTE_READ_SERIALIZER_CHECKSUM_EN
    // Explicit checksum value for bytes 0..12 is 0x0C
    LOAD_VALID = 1'b1; LOAD_VALUE = wk;
    @(negedge CLK);
    LOAD_VALID = 1'b0;
    repeat (12) @(negedge CLK);
    chk("cs_b12_last", 32'(OUT_LAST), 32'd0);
    @(negedge CLK);
    chk("cs_value", 32'(OUTPUT_VALUE), 32'h0C);
    chk("cs_num",   32'(BYTE_NUM), 32'd13);
    chk("cs_last",  32'(OUT_LAST), 32'd1);
    @(negedge CLK);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
